// File: rtl/control_unit.sv
// LEGv8 multi-cycle decoder/sequencer: turns the instruction word into the datapath control word
// and immediate, stretching LDUR and CBZ/CBNZ over two cycles and halting on undecodable words.
module control_unit (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_instruction,
    input  logic [3:0]  i_status,
    input  logic [3:0]  i_flags,
    output logic [35:0] o_control_word,
    output logic [63:0] o_constant,
    output logic [1:0]  o_state,
    output logic        o_halted
);

    typedef enum logic [1:0] {StExec = 2'b00, StMem = 2'b01, StBranch = 2'b10, StHalt = 2'b11} state_t;

    localparam logic [4:0] FsAnd = 5'b00000;
    localparam logic [4:0] FsOr  = 5'b00100;
    localparam logic [4:0] FsAdd = 5'b01000;
    localparam logic [4:0] FsSub = 5'b01001;
    localparam logic [4:0] FsXor = 5'b01100;
    localparam logic [4:0] FsLsl = 5'b10000;
    localparam logic [4:0] FsLsr = 5'b10100;

    state_t r_state, w_next_state;
    logic   r_z, w_z_next;

    logic [4:0]  w_da, w_sa, w_sb, w_fs;
    logic        w_wr, w_bsel, w_c0, w_en_b, w_en_addr_alu, w_en_alu;
    logic        w_mem_read, w_mem_write, w_status_load, w_pcsel, w_en_pc;
    logic [1:0]  w_size, w_ps;
    logic [63:0] w_const;

    logic [10:0] w_op11;
    logic [9:0]  w_op10;
    logic [4:0]  w_rd, w_rn, w_rm;
    logic [63:0] w_k_imm, w_k_d, w_k_mov, w_k_sh, w_k_b, w_k_cb;
    logic [2:0]  w_csel;
    logic        w_fz, w_fn, w_fc, w_fv, w_cond_base, w_cond_taken, w_cb_taken;
    logic        w_unused;

    assign w_op11 = i_instruction[31:21];
    assign w_op10 = i_instruction[31:22];
    assign w_rd   = i_instruction[4:0];
    assign w_rn   = i_instruction[9:5];
    assign w_rm   = i_instruction[20:16];

    assign w_k_imm = {52'd0, i_instruction[21:10]};
    assign w_k_d   = {{55{i_instruction[20]}}, i_instruction[20:12]};
    assign w_k_mov = {48'd0, i_instruction[20:5]} << {i_instruction[22:21], 4'b0000};
    assign w_k_sh  = {58'd0, i_instruction[15:10]};
    assign w_k_b   = {{38{i_instruction[25]}}, i_instruction[25:0]};
    assign w_k_cb  = {{45{i_instruction[23]}}, i_instruction[23:5]};

    assign {w_fv, w_fc, w_fn, w_fz} = i_flags;
    assign w_csel = i_instruction[3:1];
    always_comb begin
        case (w_csel)
            3'd0:    w_cond_base = w_fz;
            3'd1:    w_cond_base = w_fc;
            3'd2:    w_cond_base = w_fn;
            3'd3:    w_cond_base = w_fv;
            3'd4:    w_cond_base = w_fc & ~w_fz;
            3'd5:    w_cond_base = (w_fn == w_fv);
            3'd6:    w_cond_base = ~w_fz & (w_fn == w_fv);
            default: w_cond_base = 1'b1;
        endcase
    end
    // Conditions 14 and 15 are both "always"; otherwise bit 0 inverts the base test.
    assign w_cond_taken = (w_csel == 3'd7) ? 1'b1 : (w_cond_base ^ i_instruction[0]);
    // Opcode bit 24 distinguishes CBNZ (B5) from CBZ (B4).
    assign w_cb_taken   = i_instruction[24] ? ~r_z : r_z;
    assign w_unused     = ^i_status[3:1];

    always_comb begin
        w_next_state  = r_state;
        w_z_next      = r_z;
        w_da          = 5'd0;
        w_sa          = 5'd0;
        w_sb          = 5'd0;
        w_fs          = FsAnd;
        w_wr          = 1'b0;
        w_bsel        = 1'b0;
        w_c0          = 1'b0;
        w_en_b        = 1'b0;
        w_en_addr_alu = 1'b0;
        w_en_alu      = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_status_load = 1'b0;
        w_pcsel       = 1'b0;
        w_en_pc       = 1'b0;
        w_size        = 2'b00;
        w_ps          = 2'b00;
        w_const       = 64'd0;
        case (r_state)
            StExec: begin
                if (w_op11 inside {11'h458, 11'h558, 11'h658, 11'h758, 11'h450, 11'h550, 11'h650}) begin
                    w_da = w_rd; w_sa = w_rn; w_sb = w_rm;
                    w_en_alu = 1'b1; w_wr = 1'b1; w_ps = 2'b01;
                    case (w_op11)
                        11'h458: w_fs = FsAdd;
                        11'h558: begin w_fs = FsAdd; w_status_load = 1'b1; end
                        11'h658: begin w_fs = FsSub; w_c0 = 1'b1; end
                        11'h758: begin w_fs = FsSub; w_c0 = 1'b1; w_status_load = 1'b1; end
                        11'h450: w_fs = FsAnd;
                        11'h550: w_fs = FsOr;
                        default: w_fs = FsXor;
                    endcase
                end else if (w_op11 == 11'h69B || w_op11 == 11'h69A) begin
                    w_da = w_rd; w_sa = w_rn; w_sb = w_rm; w_bsel = 1'b1;
                    w_fs = w_op11[0] ? FsLsl : FsLsr;
                    w_en_alu = 1'b1; w_wr = 1'b1; w_ps = 2'b01; w_const = w_k_sh;
                end else if (w_op10 inside {10'h244, 10'h344, 10'h248, 10'h2C8, 10'h348}) begin
                    w_da = w_rd; w_sa = w_rn; w_bsel = 1'b1;
                    w_en_alu = 1'b1; w_wr = 1'b1; w_ps = 2'b01; w_const = w_k_imm;
                    case (w_op10)
                        10'h244: w_fs = FsAdd;
                        10'h344: begin w_fs = FsSub; w_c0 = 1'b1; end
                        10'h248: w_fs = FsAnd;
                        10'h2C8: w_fs = FsOr;
                        default: w_fs = FsXor;
                    endcase
                end else if (i_instruction[31:23] == 9'h1A5) begin
                    w_da = w_rd; w_sa = 5'd31; w_bsel = 1'b1; w_fs = FsAdd;
                    w_en_alu = 1'b1; w_wr = 1'b1; w_ps = 2'b01; w_const = w_k_mov;
                end else if (w_op11 == 11'h7C0) begin
                    w_sa = w_rn; w_sb = w_rd; w_bsel = 1'b1; w_fs = FsAdd;
                    w_en_addr_alu = 1'b1; w_en_b = 1'b1; w_mem_write = 1'b1;
                    w_size = 2'b11; w_ps = 2'b01; w_const = w_k_d;
                end else if (w_op11 == 11'h7C2) begin
                    w_da = w_rd; w_sa = w_rn; w_bsel = 1'b1; w_fs = FsAdd;
                    w_en_addr_alu = 1'b1; w_mem_read = 1'b1; w_size = 2'b11;
                    w_const = w_k_d; w_next_state = StMem;
                end else if (w_op11 == 11'h6B0) begin
                    w_sa = w_rn; w_ps = 2'b10;
                end else if (i_instruction[31:26] == 6'h05 || i_instruction[31:26] == 6'h25) begin
                    w_pcsel = 1'b1; w_ps = 2'b11; w_const = w_k_b;
                    if (i_instruction[31]) begin
                        w_en_pc = 1'b1; w_wr = 1'b1; w_da = 5'd30;
                    end
                end else if (i_instruction[31:24] == 8'hB4 || i_instruction[31:24] == 8'hB5) begin
                    w_sa = w_rd; w_sb = 5'd31; w_fs = FsAdd; w_const = w_k_cb;
                    w_z_next = i_status[0];
                    w_next_state = StBranch;
                end else if (i_instruction[31:24] == 8'h54) begin
                    w_const = w_k_cb;
                    w_pcsel = w_cond_taken;
                    w_ps    = w_cond_taken ? 2'b11 : 2'b01;
                end else begin
                    w_next_state = StHalt;
                end
            end
            StMem: begin
                w_da = w_rd; w_sa = w_rn; w_bsel = 1'b1; w_fs = FsAdd;
                w_en_addr_alu = 1'b1; w_mem_read = 1'b1; w_size = 2'b11;
                w_wr = 1'b1; w_ps = 2'b01; w_const = w_k_d;
                w_next_state = StExec;
            end
            StBranch: begin
                w_pcsel = 1'b1;
                w_ps    = w_cb_taken ? 2'b11 : 2'b01;
                w_const = w_k_cb;
                w_next_state = StExec;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StExec;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_z     <= w_z_next;
        end
    end

    assign o_control_word = i_reset ? 36'd0 :
        {w_ps, w_en_pc, 1'b0, w_pcsel, w_status_load, w_size, w_mem_write, w_mem_read,
         w_en_alu, w_en_addr_alu, w_en_b, w_c0, w_fs, w_bsel, w_wr & (w_da != 5'd31),
         w_sb, w_sa, w_da};
    assign o_constant = i_reset ? 64'd0 : w_const;
    assign o_state    = r_state;
    assign o_halted   = (r_state == StHalt);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: table of single-cycle decodes plus hand-written
// sequences for LDUR, CBZ/CBNZ, HALT and asynchronous reset.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [3:0]  status, flags;
    logic [35:0] cw;
    logic [63:0] k;
    logic [1:0]  st;
    logic        halted;

    int n_pass  = 0;
    int n_total = 0;

    control_unit dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_instruction  (instr),
        .i_status       (status),
        .i_flags        (flags),
        .o_control_word (cw),
        .o_constant     (k),
        .o_state        (st),
        .o_halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  flags;
        logic [35:0] cw;
        logic [63:0] k;
    } vec_t;

    vec_t vecs[16];

    // Field order: ps, en_pc, pcsel, status_load, size, mem_write, mem_read, en_alu,
    // en_addr_alu, en_b, c0, fs, bsel, wr, sb, sa, da
    function automatic logic [35:0] mk(input logic [1:0] ps, input logic en_pc, input logic pcsel,
                                       input logic sl, input logic [1:0] size, input logic mw,
                                       input logic mr, input logic en_alu, input logic en_aa,
                                       input logic en_b, input logic c0, input logic [4:0] fs,
                                       input logic bsel, input logic wr, input logic [4:0] sb,
                                       input logic [4:0] sa, input logic [4:0] da);
        return {ps, en_pc, 1'b0, pcsel, sl, size, mw, mr, en_alu, en_aa, en_b, c0, fs, bsel, wr,
                sb, sa, da};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"ADDI", 32'h910017E1, 4'h0,
                     mk(2'b01,0,0,0,2'b00,0,0,1,0,0,0,5'b01000,1,1,5'd0,5'd31,5'd1), 64'd5};
        vecs[1]  = '{"SUB", 32'hCB020023, 4'h0,
                     mk(2'b01,0,0,0,2'b00,0,0,1,0,0,1,5'b01001,0,1,5'd2,5'd1,5'd3), 64'd0};
        vecs[2]  = '{"ADDS", 32'hAB0600A4, 4'h0,
                     mk(2'b01,0,0,1,2'b00,0,0,1,0,0,0,5'b01000,0,1,5'd6,5'd5,5'd4), 64'd0};
        vecs[3]  = '{"ADD_X31", 32'h8B02003F, 4'h0,
                     mk(2'b01,0,0,0,2'b00,0,0,1,0,0,0,5'b01000,0,0,5'd2,5'd1,5'd31), 64'd0};
        vecs[4]  = '{"LSL", 32'hD3600C41, 4'h0,
                     mk(2'b01,0,0,0,2'b00,0,0,1,0,0,0,5'b10000,1,1,5'd0,5'd2,5'd1), 64'd3};
        vecs[5]  = '{"MOVZ", 32'hD2A24687, 4'h0,
                     mk(2'b01,0,0,0,2'b00,0,0,1,0,0,0,5'b01000,1,1,5'd0,5'd31,5'd7),
                     64'h0000_0000_1234_0000};
        vecs[6]  = '{"STUR", 32'hF8010022, 4'h0,
                     mk(2'b01,0,0,0,2'b11,1,0,0,1,1,0,5'b01000,1,0,5'd2,5'd1,5'd0), 64'd16};
        vecs[7]  = '{"BR", 32'hD60003C0, 4'h0,
                     mk(2'b10,0,0,0,2'b00,0,0,0,0,0,0,5'b00000,0,0,5'd0,5'd30,5'd0), 64'd0};
        vecs[8]  = '{"B", 32'h17FFFFFE, 4'h0,
                     mk(2'b11,0,1,0,2'b00,0,0,0,0,0,0,5'b00000,0,0,5'd0,5'd0,5'd0),
                     64'hFFFF_FFFF_FFFF_FFFE};
        vecs[9]  = '{"BL", 32'h94000008, 4'h0,
                     mk(2'b11,1,1,0,2'b00,0,0,0,0,0,0,5'b00000,0,1,5'd0,5'd0,5'd30), 64'd8};
        vecs[10] = '{"BGT_taken", 32'h5400006C, 4'b0000,
                     mk(2'b11,0,1,0,2'b00,0,0,0,0,0,0,5'b00000,0,0,5'd0,5'd0,5'd0), 64'd3};
        vecs[11] = '{"BGT_not", 32'h5400006C, 4'b0001,
                     mk(2'b01,0,0,0,2'b00,0,0,0,0,0,0,5'b00000,0,0,5'd0,5'd0,5'd0), 64'd3};
        vecs[12] = '{"BEQ_taken", 32'h54000060, 4'b0001,
                     mk(2'b11,0,1,0,2'b00,0,0,0,0,0,0,5'b00000,0,0,5'd0,5'd0,5'd0), 64'd3};
        vecs[13] = '{"BLE_taken", 32'h5400006D, 4'b1000,
                     mk(2'b11,0,1,0,2'b00,0,0,0,0,0,0,5'b00000,0,0,5'd0,5'd0,5'd0), 64'd3};
        vecs[14] = '{"ANDI", 32'h9203FC41, 4'h0,
                     mk(2'b01,0,0,0,2'b00,0,0,1,0,0,0,5'b00000,1,1,5'd0,5'd2,5'd1), 64'hFF};
        vecs[15] = '{"EOR", 32'hCA030041, 4'h0,
                     mk(2'b01,0,0,0,2'b00,0,0,1,0,0,0,5'b01100,0,1,5'd3,5'd2,5'd1), 64'd0};

        rst = 1'b1; instr = 32'h910017E1; status = 4'h0; flags = 4'h0;
        #2;
        chk("reset_cw", {28'd0, cw}, 64'd0);
        chk("reset_const", k, 64'd0);
        chk("reset_state", {62'd0, st}, 64'd0);
        chk("reset_halted", {63'd0, halted}, 64'd0);
        tick;
        rst = 1'b0;
        #1;

        for (int i = 0; i < 16; i++) begin
            instr = vecs[i].instr;
            flags = vecs[i].flags;
            #1;
            chk({vecs[i].name, "_cw"}, {28'd0, cw}, {28'd0, vecs[i].cw});
            chk({vecs[i].name, "_const"}, k, vecs[i].k);
            tick;
            chk({vecs[i].name, "_state"}, {62'd0, st}, 64'd0);
        end

        // LDUR X2,[X1,#-8]: EXEC then MEM then back to EXEC
        instr = 32'hF85F8022;
        #1;
        chk("ldur_exec_cw", {28'd0, cw},
            {28'd0, mk(2'b00,0,0,0,2'b11,0,1,0,1,0,0,5'b01000,1,0,5'd0,5'd1,5'd2)});
        chk("ldur_exec_const", k, 64'hFFFF_FFFF_FFFF_FFF8);
        tick;
        chk("ldur_mem_state", {62'd0, st}, 64'd1);
        chk("ldur_mem_cw", {28'd0, cw},
            {28'd0, mk(2'b01,0,0,0,2'b11,0,1,0,1,0,0,5'b01000,1,1,5'd0,5'd1,5'd2)});
        tick;
        chk("ldur_back_state", {62'd0, st}, 64'd0);

        // CBZ X3,+4 with Z=1; status changes after sampling must not matter
        instr = 32'hB4000083; status = 4'b0001;
        #1;
        chk("cbz_exec_cw", {28'd0, cw},
            {28'd0, mk(2'b00,0,0,0,2'b00,0,0,0,0,0,0,5'b01000,0,0,5'd31,5'd3,5'd0)});
        chk("cbz_exec_const", k, 64'd4);
        tick;
        status = 4'b0000;
        #1;
        chk("cbz_branch_state", {62'd0, st}, 64'd2);
        chk("cbz_taken_cw", {28'd0, cw},
            {28'd0, mk(2'b11,0,1,0,2'b00,0,0,0,0,0,0,5'b00000,0,0,5'd0,5'd0,5'd0)});
        chk("cbz_taken_const", k, 64'd4);
        tick;
        chk("cbz_back_state", {62'd0, st}, 64'd0);
        // CBZ with Z=0: falls through
        tick;
        chk("cbz_nt_state", {62'd0, st}, 64'd2);
        chk("cbz_not_cw", {28'd0, cw},
            {28'd0, mk(2'b01,0,1,0,2'b00,0,0,0,0,0,0,5'b00000,0,0,5'd0,5'd0,5'd0)});
        tick;
        // CBNZ with Z=0: taken
        instr = 32'hB5000083; status = 4'b0000;
        tick;
        chk("cbnz_taken_ps", {62'd0, cw[35:34]}, 64'd3);
        tick;
        chk("cbnz_back_state", {62'd0, st}, 64'd0);

        // Undecodable word halts until reset
        instr = 32'h0000_0000;
        tick;
        chk("halt_state", {62'd0, st}, 64'd3);
        instr = 32'h910017E1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("halt_cw", {28'd0, cw}, 64'd0);
            chk("halt_flag", {63'd0, halted}, 64'd1);
            tick;
        end
        chk("halt_const", k, 64'd0);
        rst = 1'b1;
        #1;
        chk("halt_reset_state", {62'd0, st}, 64'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("post_halt_halted", {63'd0, halted}, 64'd0);

        // Asynchronous reset in the middle of LDUR MEM
        instr = 32'hF85F8022;
        tick;
        chk("mid_ldur_state", {62'd0, st}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_reset_state", {62'd0, st}, 64'd0);
        chk("mid_reset_cw", {28'd0, cw}, 64'd0);
        chk("mid_reset_const", k, 64'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("after_reset_ldur_ps", {62'd0, cw[35:34]}, 64'd0);
        chk("after_reset_ldur_rd", {62'd0, cw[27:26]}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle instruction decoder and sequencer for the LEGv8 core. Sits directly upstream of the datapath: consumes the 32-bit instruction word read from instruction ROM plus ALU status and stored flags, and produces the 36-bit control word and 64-bit constant that drive register file, ALU, RAM and program counter. A small FSM stretches loads and compare-and-branch over two cycles and halts the core on an undecodable instruction.

## Interface
- No parameters.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instruction  in  32  current instruction word from instruction ROM
- status  in  4  live ALU status {V,C,N,Z} (bit0 = Z)
- flags  in  4  registered flags {V,C,N,Z}
- control_word  out  36  fields: DA[4:0] SA[9:5] SB[14:10] WR[15] Bsel[16] FS[21:17] C0[22] EN_B[23] EN_ADDR_ALU[24] EN_ALU[25] mem_read[26] mem_write[27] size[29:28] Status_load[30] PCsel[31] EN_ADDR_PC[32] EN_PC[33] PS[35:34]
- constant  out  64  immediate / offset
- state  out  2  EXEC=00, MEM=01, BRANCH=10, HALT=11
- halted  out  1  high in HALT

## Operation
- FS: FS[4:2] 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR; FS[1] invert A; FS[0] invert B. SUB = FS 01001, C0=1.
- PS: 00 hold, 01 PC+4, 10 PC←pc_in, 11 PC←PC+(pc_in<<2). PCsel=1 selects constant as pc_in, 0 selects A.
- Register fields: Rd/Rt=instr[4:0], Rn=instr[9:5], Rm=instr[20:16]. WR forced 0 whenever DA=31. EN_ADDR_PC always 0. size=11 for LDUR/STUR, else 00.
- Constants: I-type zero-ext instr[21:10]; D-type sign-ext instr[20:12]; MOVZ instr[20:5]<<(16*instr[22:21]); shifts zero-ext instr[15:10]; B/BL sign-ext instr[25:0]; CB/B.cond sign-ext instr[23:5]; otherwise 0.
- Decode (EXEC): R-type instr[31:21]: ADD 458, ADDS 558, SUB 658, SUBS 758, AND 450, ORR 550, EOR 650 (SA=Rn, SB=Rm, Bsel=0, EN_ALU, WR, PS=01; ADDS/SUBS Status_load=1). LSL 69B / LSR 69A (Bsel=1). I-type instr[31:22]: ADDI 244, SUBI 344, ANDI 248, ORRI 2C8, EORI 348 (Bsel=1). MOVZ instr[31:23]=1A5: SA=31, ADD, Bsel=1.
- STUR (7C0): SA=Rn, SB=Rt, Bsel=1, ADD, EN_ADDR_ALU, EN_B, mem_write, PS=01; one cycle.
- LDUR (7C2): EXEC: SA=Rn, Bsel=1, ADD, EN_ADDR_ALU, mem_read, WR=0, PS=00 → MEM. MEM: same fields, WR=1, DA=Rt, PS=01 → EXEC.
- BR (6B0): SA=Rn, PCsel=0, PS=10. B (instr[31:26]=05): PCsel=1, PS=11. BL (25): as B plus EN_PC, WR, DA=30.
- CBZ (B4) / CBNZ (B5): EXEC: SA=Rt, SB=31, ADD, WR=0, Status_load=0, PS=00; z_q←status[0] → BRANCH. BRANCH: PCsel=1, PS=11 if taken (CBZ: z_q=1, CBNZ: z_q=0) else 01 → EXEC.
- B.cond (54): cond=instr[3:0] evaluated on flags: EQ/NE Z, HS/LO C, MI/PL N, VS/VC V, HI C&!Z, LS inverse, GE N==V, LT inverse, GT !Z&(N==V), LE inverse, 14/15 always. Taken: PCsel=1, PS=11; else PS=01. One cycle.
- Any other encoding in EXEC → HALT. HALT: control_word all-zero (PS=00), stays until reset.

## Timing
- control_word/constant combinational from state, instruction, flags, z_q; state and z_q update on rising clock.
- Latency: ALU/store/branch 1 cycle; LDUR and CBZ/CBNZ 2 cycles.
- Reset (async, any state, including mid-LDUR or BRANCH): state←EXEC, z_q←0, halted=0; control_word forced to 0 and constant to 0 while reset high.
- No combinational path from status to control_word; status only sampled into z_q.

## Test plan
- ADDI X1,X31,#5 (0x910017E1) in EXEC -> DA=1, SA=31, Bsel=1, FS=01000, EN_ALU, WR=1, PS=01, constant=5.
- LDUR X2,[X1,#-8] -> EXEC: mem_read=1, WR=0, PS=00, constant=0xFFFF_FFFF_FFFF_FFF8; next cycle MEM: WR=1, DA=2, PS=01; then EXEC.
- CBZ X3,+4 with status Z=1 -> EXEC PS=00, BRANCH PCsel=1, PS=11, constant=4; repeat with Z=0 -> BRANCH PS=01.
- B.GT with flags {V,C,N,Z}=0000 -> PS=11; flags=0001 -> PS=01.
- ADD X31,X1,X2 -> WR=0; BL -> DA=30, EN_PC=1, WR=1, PS=11.
- Instruction 0x00000000 -> HALT, halted=1, control_word=0 for 10 cycles; assert reset mid-LDUR MEM -> state=EXEC immediately, control_word=0.
